// File: rtl/keypad_scanner.sv
// keypad_scanner
//
// Matrix keypad scanner for the elevator call/floor-select panel. One column
// is driven at a time; after the row lines have had time to settle the rows
// are captured into a whole-matrix snapshot. Complete snapshots are debounced
// across scan frames. The accepted state is reported as a level (highest held
// key, any-key, multi-key), and press/release transitions are offered as
// events through a single-entry buffer.
//
// Parameters
//   ROWS        number of row sense inputs (1..8)
//   COLS        number of driven columns (2..8)
//   SCAN_CYCLES clock cycles each column is driven (>=2)
//   DEBOUNCE    identical consecutive frame snapshots needed to accept (1..15)
//   CODE_W      key code width, derived from ROWS*COLS
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active-low
//   row         row sense lines, 1 = key closed in the driven column
//   col         one-hot column drive, active-high
//   key_code    highest-index key in the accepted state (0 when none)
//   pressed     accepted state holds at least one key
//   multi       accepted state holds two or more keys
//   evt_valid   event pending
//   evt_ready   consumer accepts the pending event
//   evt_code    key code of the pending event
//   evt_release 0 = press event, 1 = release event
//   overflow    sticky: an event was dropped because the buffer was full
//
// Handshake: an event transfers on any rising clk edge where evt_valid and
// evt_ready are both high. While evt_valid is high and evt_ready is low,
// evt_code/evt_release hold steady. evt_valid never depends combinationally
// on evt_ready.

module keypad_scanner #(
    parameter  int ROWS        = 4,
    parameter  int COLS        = 4,
    parameter  int SCAN_CYCLES = 16,
    parameter  int DEBOUNCE    = 3,
    localparam int CODE_W      = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    output logic [CODE_W-1:0] key_code,
    output logic              pressed,
    output logic              multi,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CODE_W-1:0] evt_code,
    output logic              evt_release,
    output logic              overflow
);

    localparam int KEYS = ROWS * COLS;
    localparam int DW_W = $clog2(SCAN_CYCLES);
    localparam int CI_W = $clog2(COLS);

    // Highest set index wins; returns 0 for an empty vector.
    function automatic logic [CODE_W-1:0] top_key(input logic [KEYS-1:0] v);
        logic [CODE_W-1:0] k;
        k = '0;
        for (int i = 0; i < KEYS; i++) begin
            if (v[i]) k = CODE_W'(i);
        end
        return k;
    endfunction

    logic [DW_W-1:0] dwell;
    logic [CI_W-1:0] col_idx;
    logic [KEYS-1:0] snapshot;
    logic [KEYS-1:0] prev;
    logic [KEYS-1:0] stable;
    logic [3:0]      run;

    logic            dwell_end;
    logic            frame_end;
    logic [KEYS-1:0] snap_full;
    logic [3:0]      run_next;
    logic            accept;
    logic            new_has;
    logic [CODE_W-1:0] new_code;
    logic            evt_new;
    logic            evt_new_release;
    logic [CODE_W-1:0] evt_new_code;

    // ------------------------------------------------------------------
    // Scan timing
    // ------------------------------------------------------------------
    assign dwell_end = (dwell == DW_W'(SCAN_CYCLES - 1));
    assign frame_end = dwell_end && (col_idx == CI_W'(COLS - 1));
    assign col       = COLS'(1) << col_idx;

    // Snapshot with the current column's rows merged in. Captured only at
    // the end of the dwell, so earlier (settling) cycles never reach state,
    // and at frame end it already contains the final column for evaluation.
    always_comb begin
        snap_full = snapshot;
        snap_full[col_idx * ROWS +: ROWS] = row;
    end

    // ------------------------------------------------------------------
    // Debounce evaluation at frame end
    // ------------------------------------------------------------------
    always_comb begin
        run_next = 4'd1;
        if (snap_full == prev) begin
            run_next = (run == 4'd15) ? 4'd15 : run + 4'd1;
        end
    end

    assign accept   = frame_end && (run_next >= 4'(DEBOUNCE)) && (snap_full != stable);
    assign new_has  = |snap_full;
    assign new_code = top_key(snap_full);

    // An event arises only when the reported key changes: a new highest key
    // is a press, an empty new state releases the old key. If the top key is
    // unchanged (only lower keys moved) the levels update silently.
    always_comb begin
        evt_new         = 1'b0;
        evt_new_release = 1'b0;
        evt_new_code    = new_code;
        if (accept) begin
            if (new_has) begin
                evt_new = !pressed || (new_code != key_code);
            end else begin
                evt_new         = pressed;
                evt_new_release = 1'b1;
                evt_new_code    = key_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell    <= '0;
            col_idx  <= '0;
            snapshot <= '0;
            prev     <= '0;
            stable   <= '0;
            run      <= 4'd0;
        end else begin
            if (dwell_end) begin
                dwell    <= '0;
                snapshot <= snap_full;
                col_idx  <= (col_idx == CI_W'(COLS - 1)) ? '0 : col_idx + 1'b1;
            end else begin
                dwell <= dwell + 1'b1;
            end
            if (frame_end) begin
                run  <= run_next;
                prev <= snap_full;
                if (accept) stable <= snap_full;
            end
        end
    end

    // ------------------------------------------------------------------
    // Level outputs straight from the accepted state
    // ------------------------------------------------------------------
    assign key_code = top_key(stable);
    assign pressed  = |stable;
    assign multi    = |(stable & (stable - 1'b1));

    // ------------------------------------------------------------------
    // Single-entry event buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_valid   <= 1'b0;
            evt_code    <= '0;
            evt_release <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (evt_new && (!evt_valid || evt_ready)) begin
                evt_valid   <= 1'b1;
                evt_code    <= evt_new_code;
                evt_release <= evt_new_release;
            end else begin
                if (evt_new) overflow <= 1'b1;   // full and not draining: drop
                if (evt_valid && evt_ready) evt_valid <= 1'b0;
            end
        end
    end

endmodule
